// File: rtl/cpu_sequencer.sv
// Multi-cycle control unit for the 2-bit CPU: owns PC/IR, fetches over a req/valid
// handshake and issues one-cycle control strobes to the accumulator datapath.
module cpu_sequencer #(
    parameter int unsigned PC_W = 2,
    parameter int unsigned DW   = 2,
    parameter int unsigned OPW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_valid,
    input  logic [OPW+DW-1:0] imem_data,
    input  logic              acc_zero,
    output logic              ctl_acc_load,
    output logic              ctl_acc_add,
    output logic              ctl_out_load,
    output logic [DW-1:0]     ctl_imm,
    output logic              busy,
    output logic              halted
);

    localparam int unsigned IW = OPW + DW;

    localparam logic [OPW-1:0] OP_LDI  = OPW'(0);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(1);
    localparam logic [OPW-1:0] OP_MISC = OPW'(2);
    localparam logic [OPW-1:0] OP_JZ   = OPW'(3);
    localparam logic [DW-1:0]  IMM_OUT  = '0;
    localparam logic [DW-1:0]  IMM_HALT = '1;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [IW-1:0]   ir, ir_nxt;
    logic            cont, cont_nxt;
    logic [OPW-1:0]  op, op_nxt;
    logic [DW-1:0]   imm, imm_nxt;
    logic            req_nxt, load_nxt, add_nxt, out_nxt, busy_nxt, halted_nxt;
    logic [DW-1:0]   ctl_imm_nxt;

    assign op        = ir[IW-1:DW];
    assign imm       = ir[DW-1:0];
    assign imem_addr = pc;

    // Next state plus outputs computed from the next state so every output is a flop.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        ir_nxt      = ir;
        cont_nxt    = cont;
        op_nxt      = '0;
        imm_nxt     = '0;
        req_nxt     = 1'b0;
        load_nxt    = 1'b0;
        add_nxt     = 1'b0;
        out_nxt     = 1'b0;
        ctl_imm_nxt = '0;
        busy_nxt    = 1'b0;
        halted_nxt  = 1'b0;

        unique case (state)
            IDLE: begin
                if (run) begin
                    state_nxt = FETCH;
                    cont_nxt  = 1'b1;
                end else if (step) begin
                    state_nxt = FETCH;
                    cont_nxt  = 1'b0;
                end
            end
            FETCH: begin
                if (imem_valid) begin
                    ir_nxt    = imem_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                pc_nxt    = pc + PC_W'(1);
                state_nxt = (cont && run) ? FETCH : IDLE;
                if (op == OP_JZ && acc_zero) begin
                    pc_nxt = PC_W'(imm);
                end
                if (op == OP_MISC && imm == IMM_HALT) begin
                    pc_nxt    = pc;
                    state_nxt = HALT;
                end
            end
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase

        op_nxt     = ir_nxt[IW-1:DW];
        imm_nxt    = ir_nxt[DW-1:0];
        req_nxt    = (state_nxt == FETCH);
        busy_nxt   = (state_nxt == FETCH) || (state_nxt == EXEC);
        halted_nxt = (state_nxt == HALT);
        if (state_nxt == EXEC) begin
            ctl_imm_nxt = imm_nxt;
            load_nxt    = (op_nxt == OP_LDI);
            add_nxt     = (op_nxt == OP_ADD);
            out_nxt     = (op_nxt == OP_MISC) && (imm_nxt == IMM_OUT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pc           <= '0;
            ir           <= '0;
            cont         <= 1'b0;
            imem_req     <= 1'b0;
            ctl_acc_load <= 1'b0;
            ctl_acc_add  <= 1'b0;
            ctl_out_load <= 1'b0;
            ctl_imm      <= '0;
            busy         <= 1'b0;
            halted       <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            ir           <= ir_nxt;
            cont         <= cont_nxt;
            imem_req     <= req_nxt;
            ctl_acc_load <= load_nxt;
            ctl_acc_add  <= add_nxt;
            ctl_out_load <= out_nxt;
            ctl_imm      <= ctl_imm_nxt;
            busy         <= busy_nxt;
            halted       <= halted_nxt;
        end
    end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: behavioural instruction memory with programmable
// wait states and a scoreboard of expected (cycle, strobe, immediate) events.
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic       imem_req;
    logic [1:0] imem_addr;
    logic       imem_valid = 1'b0;
    logic [3:0] imem_data = '0;
    logic       acc_zero = 1'b0;
    logic       ctl_acc_load, ctl_acc_add, ctl_out_load;
    logic [1:0] ctl_imm;
    logic       busy, halted;

    int tests = 0;
    int fails = 0;
    int rel = 0;
    int wait_n = 0;
    int wcnt = 0;
    logic waiting = 1'b0;
    logic [1:0] prev_addr = '0;
    logic [3:0] mem [4];
    int exp_q [$];
    int fetch_q [$];

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data),
        .acc_zero(acc_zero),
        .ctl_acc_load(ctl_acc_load), .ctl_acc_add(ctl_acc_add),
        .ctl_out_load(ctl_out_load), .ctl_imm(ctl_imm),
        .busy(busy), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pk(int cyc, logic l, logic a, logic o, logic [1:0] imm);
        return (cyc << 8) | (int'({l, a, o}) << 4) | int'(imm);
    endfunction

    function automatic logic [31:0] outs();
        return 32'({imem_req, imem_addr, ctl_acc_load, ctl_acc_add, ctl_out_load,
                    ctl_imm, busy, halted});
    endfunction

    // Fetch log as one nibble per fetch (address+1), first fetch in the low nibble.
    function automatic logic [31:0] fq_sig();
        logic [31:0] v = '0;
        for (int i = 0; i < fetch_q.size(); i++) v |= 32'(fetch_q[i] + 1) << (4 * i);
        return v;
    endfunction

    // One clock: score strobes, then play instruction memory for the next edge.
    task automatic tick();
        int e;
        @(negedge clk);
        rel++;
        if (ctl_acc_load || ctl_acc_add || ctl_out_load) begin
            check("one_strobe", 32'(ctl_acc_load) + 32'(ctl_acc_add) + 32'(ctl_out_load), 32'd1);
            check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("strobe", 32'(pk(rel, ctl_acc_load, ctl_acc_add, ctl_out_load, ctl_imm)), 32'(e));
            end
        end
        if (imem_req) begin
            if (waiting) check("addr_stable", 32'(imem_addr), 32'(prev_addr));
            prev_addr = imem_addr;
            if (wcnt >= wait_n) begin
                imem_valid = 1'b1;
                imem_data  = mem[imem_addr];
                fetch_q.push_back(int'(imem_addr));
                wcnt    = 0;
                waiting = 1'b0;
            end else begin
                imem_valid = 1'b0;
                imem_data  = 4'($urandom);
                wcnt++;
                waiting = 1'b1;
            end
        end else begin
            imem_valid = 1'($urandom);
            imem_data  = 4'($urandom);
            wcnt    = 0;
            waiting = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; run = 1'b0; step = 1'b0; acc_zero = 1'b0;
        imem_valid = 1'b0; wcnt = 0; waiting = 1'b0;
        #1;
        check("reset_outs", outs(), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1; rel = 0;
        fetch_q.delete(); exp_q.delete();
    endtask

    task automatic load_prog();
        mem[0] = 4'b0001; mem[1] = 4'b0110; mem[2] = 4'b1000; mem[3] = 4'b1011;
    endtask

    task automatic push_prog(int w);
        exp_q.push_back(pk(1 * (2 + w), 1'b1, 1'b0, 1'b0, 2'd1));
        exp_q.push_back(pk(2 * (2 + w), 1'b0, 1'b1, 1'b0, 2'd2));
        exp_q.push_back(pk(3 * (2 + w), 1'b0, 1'b0, 1'b1, 2'd0));
    endtask

    initial begin
        load_prog();

        // Reset and idle
        do_reset();
        repeat (10) begin
            tick();
            check("idle_outs", outs(), 32'd0);
        end

        // Zero-wait program run
        do_reset(); load_prog(); wait_n = 0; push_prog(0);
        run = 1'b1;
        repeat (8) tick();
        check("halt_exec_not_halted", 32'({busy, halted}), 32'b10);
        tick();
        check("halted_c9", 32'({busy, halted}), 32'b01);
        step = 1'b1; run = 1'b0;
        repeat (3) tick();
        run = 1'b1; step = 1'b0;
        repeat (3) tick();
        check("halt_sticky", 32'({imem_req, busy, halted}), 32'b001);
        check("zw_fetches", fq_sig(), 32'h4321);
        check("zw_sb_empty", 32'(exp_q.size()), 32'd0);

        // Three wait states per fetch
        do_reset(); load_prog(); wait_n = 3; push_prog(3);
        run = 1'b1;
        repeat (20) tick();
        check("ws_halt_exec", 32'({busy, halted}), 32'b10);
        tick();
        check("ws_halted", 32'({busy, halted}), 32'b01);
        check("ws_fetches", fq_sig(), 32'h4321);
        check("ws_sb_empty", 32'(exp_q.size()), 32'd0);

        // Single step, with a second pulse during FETCH ignored
        do_reset(); load_prog(); wait_n = 3;
        exp_q.push_back(pk(5, 1'b1, 1'b0, 1'b0, 2'd1));
        step = 1'b1; tick(); step = 1'b0;
        tick();
        step = 1'b1; tick(); step = 1'b0;
        repeat (7) tick();
        check("step_idle", 32'({imem_req, busy, halted}), 32'b000);
        check("step_pc", 32'(imem_addr), 32'd1);
        check("step_fetches", fq_sig(), 32'h1);
        check("step_sb_empty", 32'(exp_q.size()), 32'd0);

        // JZ taken
        do_reset(); wait_n = 0; mem[0] = 4'b1110; acc_zero = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        repeat (4) tick();
        check("jz_taken_pc", 32'(imem_addr), 32'd2);

        // JZ not taken
        do_reset(); mem[0] = 4'b1110; acc_zero = 1'b0;
        step = 1'b1; tick(); step = 1'b0;
        repeat (4) tick();
        check("jz_fall_pc", 32'(imem_addr), 32'd1);

        // Jump to 3, NOP at 3 wraps PC to 0
        do_reset(); mem[0] = 4'b1111; mem[3] = 4'b1001; acc_zero = 1'b1;
        step = 1'b1; tick(); step = 1'b0;
        repeat (4) tick();
        check("jz3_pc", 32'(imem_addr), 32'd3);
        step = 1'b1; tick(); step = 1'b0;
        repeat (4) tick();
        check("wrap_pc", 32'(imem_addr), 32'd0);
        check("wrap_fetches", fq_sig(), 32'h41);
        check("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during EXEC of ADD
        do_reset(); load_prog(); wait_n = 0; push_prog(0);
        run = 1'b1;
        repeat (4) tick();
        check("pre_reset_add", 32'({ctl_acc_add, ctl_imm}), 32'b110);
        reset = 1'b0;
        #1;
        check("reset_async", outs(), 32'd0);
        repeat (2) @(negedge clk);
        exp_q.delete(); fetch_q.delete(); wcnt = 0; waiting = 1'b0;
        push_prog(0);
        reset = 1'b1; rel = 0;
        tick();
        check("post_reset_fetch", 32'({imem_req, imem_addr, halted}), 32'b1000);
        repeat (8) tick();
        check("post_reset_halted", 32'(halted), 32'd1);
        check("post_reset_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
